ball_motion_sched: RTL and testbench

- Frame-synchronous motion scheduler for the 3x3 ball instances.
- Generates one `move` strobe per ball, once per frame at most, placed in vertical blanking. Each ball's neighbour-occupancy capture therefore completes over the visible frame before any position update.
- Provides per-ball speed division, a serve hold-off after reset or on request, and frame-synchronous pause.
- Sits between the VGA timing generator (hcount/vcount/pixpulse) and the ball instances' `move` inputs.

---
 rtl/ball_motion_sched.sv | 126 ++++++++++++
 tb/tb_ball_motion_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_sched.sv
// Frame-synchronous move scheduler for the ball array: one move strobe per ball
// per frame at most, issued at a vertical-blanking trigger pixel, with speed division, serve hold-off and pause.
module ball_motion_sched #(
  parameter int unsigned NBALLS       = 2,
  parameter int unsigned H_TRIG       = 0,
  parameter int unsigned V_TRIG       = 481,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixpulse,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic [2*NBALLS-1:0]   speed,
  input  logic                  pause,
  input  logic                  serve,
  output logic [NBALLS-1:0]     move,
  output logic                  frame_tick,
  output logic [1:0]            state,
  output logic [15:0]           frame_count
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned SPEED_W = 2;
  localparam int unsigned FC_W    = 16;
  localparam int unsigned CNT_W   = SPEED_W * NBALLS;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'b00,
    RUN        = 2'b01,
    PAUSED     = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                serve_pend_q, serve_pend_d;
  logic [NBALLS-1:0]   move_d;
  logic                frame_tick_d;
  logic [FC_W-1:0]     frame_count_d;
  logic                trigger_c;

  // One pixel per frame, chosen inside vertical blanking.
  assign trigger_c = pixpulse
                   && (hcount == 10'(H_TRIG))
                   && (vcount == 10'(V_TRIG));

  // Next-state and output decode; everything only changes at a trigger except
  // serve capture and the move clear on the following pixel enable.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    cnt_d         = cnt_q;
    serve_pend_d  = serve_pend_q | serve;
    move_d        = pixpulse ? '0 : move;
    frame_tick_d  = trigger_c;
    frame_count_d = frame_count;

    if (trigger_c) begin
      // A serve landing on the trigger edge is kept for the next frame.
      serve_pend_d  = serve;
      frame_count_d = frame_count + FC_W'(1);
      move_d        = '0;

      if (serve_pend_q) begin
        state_d = SERVE_WAIT;
        wait_d  = WAIT_W'(SERVE_FRAMES);
        cnt_d   = '0;
      end else if (pause) begin
        if (state_q != SERVE_WAIT) begin
          state_d = PAUSED;
        end
      end else begin
        case (state_q)
          SERVE_WAIT: begin
            if (wait_q == WAIT_W'(1)) begin
              state_d = RUN;
            end else begin
              wait_d = wait_q - WAIT_W'(1);
            end
          end
          RUN, PAUSED: begin
            state_d = RUN;
            for (int unsigned i = 0; i < NBALLS; i++) begin
              if (cnt_q[SPEED_W*i +: SPEED_W] == SPEED_W'(0)) begin
                move_d[i]                    = 1'b1;
                cnt_d[SPEED_W*i +: SPEED_W]  = speed[SPEED_W*i +: SPEED_W];
              end else begin
                cnt_d[SPEED_W*i +: SPEED_W]  = cnt_q[SPEED_W*i +: SPEED_W] - SPEED_W'(1);
              end
            end
          end
          default: begin
            state_d = SERVE_WAIT;
            wait_d  = WAIT_W'(SERVE_FRAMES);
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SERVE_WAIT;
      wait_q       <= WAIT_W'(SERVE_FRAMES);
      cnt_q        <= '0;
      serve_pend_q <= 1'b0;
      move         <= '0;
      frame_tick   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      serve_pend_q <= serve_pend_d;
      move         <= move_d;
      frame_tick   <= frame_tick_d;
      frame_count  <= frame_count_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Directed bench for ball_motion_sched: compressed frames (trigger slot plus one
// ordinary pixel slot) with hand-computed move/state expectations.
module tb_ball_motion_sched;

  localparam int unsigned NB = 2;
  localparam int unsigned SF = 3;

  localparam logic [1:0] S_WAIT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic            pixpulse;
  logic [9:0]      hcount;
  logic [9:0]      vcount;
  logic [2*NB-1:0] speed;
  logic            pause;
  logic            serve;
  logic [NB-1:0]   move;
  logic            frame_tick;
  logic [1:0]      state;
  logic [15:0]     frame_count;

  int n_cmp = 0;
  int n_err = 0;

  ball_motion_sched #(
    .NBALLS(NB), .H_TRIG(0), .V_TRIG(481), .SERVE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .speed(speed), .pause(pause), .serve(serve), .move(move),
    .frame_tick(frame_tick), .state(state), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Trigger slot, three idle clocks, one ordinary pixel slot, three idle clocks.
  task automatic frame(input string tag, input logic [1:0] exp_mv, input logic [1:0] exp_st,
                       input logic srv);
    @(negedge clk);
    pixpulse = 1'b1; hcount = 10'd0; vcount = 10'd481; serve = srv;
    @(negedge clk);
    pixpulse = 1'b0; hcount = 10'd5; vcount = 10'd100; serve = 1'b0;
    check_val({tag, "_tick"}, 16'(frame_tick), 16'd1);
    check_val({tag, "_move"}, 16'(move), 16'(exp_mv));
    check_val({tag, "_state"}, 16'(state), 16'(exp_st));
    @(negedge clk);
    check_val({tag, "_tick_off"}, 16'(frame_tick), 16'd0);
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_move_hold"}, 16'(move), 16'(exp_mv));
    pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0;
    check_val({tag, "_move_clr"}, 16'(move), 16'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pixpulse = 1'b0; hcount = 10'd5; vcount = 10'd100;
    speed = '0; pause = 1'b0; serve = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_move", 16'(move), 16'd0);
    check_val("rst_tick", 16'(frame_tick), 16'd0);
    check_val("rst_state", 16'(state), 16'(S_WAIT));
    check_val("rst_fc", frame_count, 16'd0);
    rst = 1'b0;

    // Serve hold-off then every-frame motion.
    frame("s1_t1", 2'b00, S_WAIT, 1'b0);
    frame("s1_t2", 2'b00, S_WAIT, 1'b0);
    frame("s1_t3", 2'b00, S_RUN,  1'b0);
    frame("s1_t4", 2'b11, S_RUN,  1'b0);
    frame("s1_t5", 2'b11, S_RUN,  1'b0);
    frame("s1_t6", 2'b11, S_RUN,  1'b0);
    check_val("s1_fc", frame_count, 16'd6);

    // Ball1 period 3, ball0 period 1.
    do_reset();
    speed = 4'b1000;
    frame("s2_t1",  2'b00, S_WAIT, 1'b0);
    frame("s2_t2",  2'b00, S_WAIT, 1'b0);
    frame("s2_t3",  2'b00, S_RUN,  1'b0);
    frame("s2_t4",  2'b11, S_RUN,  1'b0);
    frame("s2_t5",  2'b01, S_RUN,  1'b0);
    frame("s2_t6",  2'b01, S_RUN,  1'b0);
    frame("s2_t7",  2'b11, S_RUN,  1'b0);
    frame("s2_t8",  2'b01, S_RUN,  1'b0);
    frame("s2_t9",  2'b01, S_RUN,  1'b0);
    frame("s2_t10", 2'b11, S_RUN,  1'b0);

    // Pause for five triggers; ball1 countdown (2) must survive.
    pause = 1'b1;
    for (int k = 0; k < 5; k++) frame("s3_paused", 2'b00, S_PAUSE, 1'b0);
    pause = 1'b0;
    frame("s3_t16", 2'b01, S_RUN, 1'b0);
    frame("s3_t17", 2'b01, S_RUN, 1'b0);
    frame("s3_t18", 2'b11, S_RUN, 1'b0);
    // A pause glitch between triggers is ignored.
    pause = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b0;
    frame("s3_t19", 2'b01, S_RUN, 1'b0);

    // Serve pulse mid-frame during RUN.
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
    frame("s4_t20", 2'b00, S_WAIT, 1'b0);
    frame("s4_t21", 2'b00, S_WAIT, 1'b0);
    frame("s4_t22", 2'b00, S_WAIT, 1'b0);
    frame("s4_t23", 2'b00, S_RUN,  1'b0);
    frame("s4_t24", 2'b11, S_RUN,  1'b0);
    frame("s4_t25", 2'b01, S_RUN,  1'b0);
    // Serve on the trigger edge acts one trigger later.
    frame("s4_t26", 2'b01, S_RUN,  1'b1);
    frame("s4_t27", 2'b00, S_WAIT, 1'b0);
    frame("s4_t28", 2'b00, S_WAIT, 1'b0);
    frame("s4_t29", 2'b00, S_WAIT, 1'b0);
    frame("s4_t30", 2'b00, S_RUN,  1'b0);

    // Async reset while move is high, between pixel enables.
    @(negedge clk);
    pixpulse = 1'b1; hcount = 10'd0; vcount = 10'd481;
    @(negedge clk);
    pixpulse = 1'b0; hcount = 10'd5; vcount = 10'd100;
    check_val("s5_move_pre", 16'(move), 16'd3);
    check_val("s5_fc_pre", frame_count, 16'd31);
    #2 rst = 1'b1;
    #1;
    check_val("s5_move_rst", 16'(move), 16'd0);
    check_val("s5_fc_rst", frame_count, 16'd0);
    check_val("s5_state_rst", 16'(state), 16'(S_WAIT));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("s5_move_idle", 16'(move), 16'd0);
    pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0;
    check_val("s5_move_after", 16'(move), 16'd0);
    repeat (2) @(negedge clk);
    frame("s5_t1", 2'b00, S_WAIT, 1'b0);

    // frame_count wrap using back-to-back triggers.
    do_reset();
    @(negedge clk);
    pixpulse = 1'b1; hcount = 10'd0; vcount = 10'd481; pause = 1'b1;
    repeat (65535) @(negedge clk);
    check_val("s6_fc_max", frame_count, 16'hffff);
    @(negedge clk);
    check_val("s6_fc_wrap", frame_count, 16'd0);
    pixpulse = 1'b0; hcount = 10'd5; vcount = 10'd100; pause = 1'b0;
    @(negedge clk);
    check_val("s6_tick_off", 16'(frame_tick), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
